// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Two-entry skid-buffered inter-stage register (IR, PC, sideband)
//            with valid/ready handshake, flush-to-bubble and derived PC+8.
//            Optional perf counters under `PIPE_STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          SIDE_W   = 8,
`ifdef PIPE_STAGE_PERF_EN
  parameter int          CNT_W    = 16,
`endif
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_ir,
  input  logic [31:0]       in_pc,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_ir,
  output logic [31:0]       out_pc,
  output logic [SIDE_W-1:0] out_side,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic [31:0]       out_pc8
);

  logic              main_valid;
  logic [31:0]       main_ir;
  logic [31:0]       main_pc;
  logic [SIDE_W-1:0] main_side;
  logic              skid_valid;
  logic [31:0]       skid_ir;
  logic [31:0]       skid_pc;
  logic [SIDE_W-1:0] skid_side;

  logic accept;
  logic drain;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;
  assign drain    = main_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_ir    <= 32'd0;
      main_pc    <= PC_RESET;
      main_side  <= '0;
      skid_valid <= 1'b0;
      skid_ir    <= 32'd0;
      skid_pc    <= PC_RESET;
      skid_side  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || drain) begin
      // Skid always holds the older instruction, so it refills main first.
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_ir    <= skid_ir;
        main_pc    <= skid_pc;
        main_side  <= skid_side;
        skid_valid <= 1'b0;
      end else if (accept) begin
        main_valid <= 1'b1;
        main_ir    <= in_ir;
        main_pc    <= in_pc;
        main_side  <= in_side;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ir    <= in_ir;
      skid_pc    <= in_pc;
      skid_side  <= in_side;
    end
  end

  assign out_valid = main_valid;
  assign out_ir    = main_valid ? main_ir   : 32'd0;
  assign out_pc    = main_valid ? main_pc   : PC_RESET;
  assign out_side  = main_valid ? main_side : '0;
  assign out_pc8   = out_pc + 32'd8;

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; deliberately untouched by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_ir;
  logic [31:0] in_pc;
  logic [7:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_ir;
  logic [31:0] out_pc;
  logic [7:0]  out_side;
  logic [31:0] out_pc8;
`ifdef PIPE_STAGE_PERF_EN
  logic [1:0]  stall_cnt;
  logic [1:0]  bubble_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(
    .SIDE_W  (8),
`ifdef PIPE_STAGE_PERF_EN
    .CNT_W   (2),
`endif
    .PC_RESET(32'h0000_0000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ir     (in_ir),
    .in_pc     (in_pc),
    .in_side   (in_side),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ir    (out_ir),
    .out_pc    (out_pc),
    .out_side  (out_side),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt),
`endif
    .out_pc8   (out_pc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: queue length mirrors the number of occupied entries.
  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [7:0]  side;
  } ent_t;
  ent_t q[$];

  always @(negedge clk) begin
    ent_t e;
    if (reset) begin
      q.delete();
    end else begin
      chk("sb_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("sb_in_ready",  {31'd0, in_ready},  {31'd0, q.size() < 2});
      if (out_valid && out_ready && q.size() != 0) begin
        e = q.pop_front();
        chk("sb_ir",   out_ir,   e.ir);
        chk("sb_pc",   out_pc,   e.pc);
        chk("sb_pc8",  out_pc8,  e.pc + 32'd8);
        chk("sb_side", {24'd0, out_side}, {24'd0, e.side});
      end
      if (flush) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        e.ir = in_ir; e.pc = in_pc; e.side = in_side;
        q.push_back(e);
      end
    end
  end

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [7:0]  side;
    logic [31:0] exp_pc8;
  } vec_t;
  vec_t vecs[4];

  task automatic drive(input logic v, input logic [31:0] ir, input logic [31:0] pc, input logic [7:0] side);
    in_valid = v;
    in_ir    = ir;
    in_pc    = pc;
    in_side  = side;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_ir"},    out_ir,  32'd0);
    chk({tag, "_pc"},    out_pc,  32'd0);
    chk({tag, "_pc8"},   out_pc8, 32'd8);
    chk({tag, "_side"},  {24'd0, out_side}, 32'd0);
    chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{ir: 32'h2401_0005, pc: 32'h0000_3000, side: 8'h01, exp_pc8: 32'h0000_3008};
    vecs[1] = '{ir: 32'h2402_0007, pc: 32'h0000_3004, side: 8'h02, exp_pc8: 32'h0000_300C};
    vecs[2] = '{ir: 32'h8C43_0010, pc: 32'hFFFF_FFFC, side: 8'hA5, exp_pc8: 32'h0000_0004};
    vecs[3] = '{ir: 32'hAFBF_0018, pc: 32'h7FFF_FFF8, side: 8'hFF, exp_pc8: 32'h8000_0000};

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_idle("rst");
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall",  {30'd0, stall_cnt},  32'd0);
    chk("rst_bubble", {30'd0, bubble_cnt}, 32'd0);
    step();
    chk("bubble_1", {30'd0, bubble_cnt}, 32'd1);
`else
    step();
`endif
    chk_idle("idle");

    // Back-to-back stream at full throughput
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vecs[i].ir, vecs[i].pc, vecs[i].side);
      step();
      chk("tbl_valid", {31'd0, out_valid}, 32'd1);
      chk("tbl_ir",    out_ir,  vecs[i].ir);
      chk("tbl_pc",    out_pc,  vecs[i].pc);
      chk("tbl_pc8",   out_pc8, vecs[i].exp_pc8);
      chk("tbl_side",  {24'd0, out_side}, {24'd0, vecs[i].side});
    end
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    step();
    chk_idle("drained");

    // Back-pressure: A in main, B in skid, C held upstream
    out_ready = 1'b0;
    drive(1'b1, 32'hA000_000A, 32'h0000_4000, 8'h0A);
    step();
    chk("bp_a_ir", out_ir, 32'hA000_000A);
    chk("bp_a_rdy", {31'd0, in_ready}, 32'd1);
    drive(1'b1, 32'hB000_000B, 32'h0000_4004, 8'h0B);
    step();
    chk("bp_skid_rdy", {31'd0, in_ready}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_1", {30'd0, stall_cnt}, 32'd1);
`endif
    drive(1'b1, 32'hC000_000C, 32'h0000_4008, 8'h0C);
    repeat (4) step();
    chk("bp_hold_ir",  out_ir, 32'hA000_000A);
    chk("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_sat", {30'd0, stall_cnt}, 32'd3);
    chk("bubble_sat", {30'd0, bubble_cnt}, 32'd3);
`endif
    out_ready = 1'b1;
    step();
    chk("bp_b_ir",  out_ir, 32'hB000_000B);
    chk("bp_b_rdy", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_c_ir",  out_ir, 32'hC000_000C);
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush with both entries full, F offered at the same time
    out_ready = 1'b0;
    drive(1'b1, 32'hD000_000D, 32'h0000_5000, 8'h0D);
    step();
    drive(1'b1, 32'hE000_000E, 32'h0000_5004, 8'h0E);
    step();
    chk("fl_full_rdy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 32'hF000_000F, 32'h0000_5008, 8'h0F);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    chk_idle("flush1");

    // Flush with drain and an accepted H that must vanish
    drive(1'b1, 32'h1111_0001, 32'h0000_6000, 8'h11);
    step();
    drive(1'b1, 32'h2222_0002, 32'h0000_6004, 8'h22);
    flush = 1'b1;
    out_ready = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    chk_idle("flush2");
    step();
    chk_idle("flush2_after");

    // Asynchronous reset mid-cycle with a live entry
    out_ready = 1'b0;
    drive(1'b1, 32'h3333_0003, 32'h0000_7000, 8'h33);
    step();
    chk("ar_loaded", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 32'd0, 32'd0, 8'd0);
    #2 reset = 1'b1;
    #1;
    chk_idle("async_rst");
`ifdef PIPE_STAGE_PERF_EN
    chk("ar_stall", {30'd0, stall_cnt}, 32'd0);
`endif
    step();
    reset = 1'b0;
    step();
    chk_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
